// File: rtl/bcss_pkg.sv
// Shared types and defaults for the block-carry-speculative sequential subtractor.
package bcss_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SPEC  = 3;
    localparam int unsigned BLK       = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest bit of the carry-prediction window feeding block k.
    function automatic int unsigned win_lo(input int unsigned k, input int unsigned spec);
        return (BLK * k >= spec) ? (BLK * k - spec) : 32'd0;
    endfunction

endpackage

// File: rtl/bcss_block2.sv
// One 2-bit slice of a + nb with its carry-in predicted from a short window of lower bits.
module bcss_block2
    import bcss_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SPEC  = DEF_SPEC,
    parameter int unsigned CNT_W = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] nb,
    input  logic [CNT_W-1:0] k,
    output logic [1:0]       sum,
    output logic             cout
);

    int unsigned lo;
    int unsigned hi;
    logic        c;
    logic [2:0]  s3;

    always_comb begin
        lo = win_lo(32'(k), SPEC);
        hi = BLK * 32'(k);
        // A window reaching bit 0 sees the true +1 of two's complement; a truncated one assumes 0.
        c  = (lo == 32'd0);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((i >= lo) && (i < hi)) begin
                c = (a[i] & nb[i]) | (c & (a[i] ^ nb[i]));
            end
        end
        s3   = {1'b0, a[hi +: BLK]} + {1'b0, nb[hi +: BLK]} + {2'b00, c};
        sum  = s3[1:0];
        cout = s3[2];
    end

endmodule

// File: rtl/bcss_seq16.sv
// Iterative approximate subtractor: one speculated 2-bit block of a - b per clock.
// Optional BCSS_SEQ16_ERR_EN adds the exact result and a mismatch flag.
module bcss_seq16
    import bcss_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SPEC  = DEF_SPEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef BCSS_SEQ16_ERR_EN
    ,
    output logic             err,
    output logic [WIDTH:0]   exact
`endif
);

    localparam int unsigned NBLK  = WIDTH / BLK;
    localparam int unsigned CNT_W = $clog2(NBLK);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   nb_q,        nb_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               borrow_q,    borrow_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         blk_sum;
    logic               blk_cout;
`ifdef BCSS_SEQ16_ERR_EN
    logic               err_q,       err_d;
    logic [WIDTH:0]     exact_q,     exact_d;
    logic [WIDTH:0]     ex_sum;
`endif

    bcss_block2 #(
        .WIDTH (WIDTH),
        .SPEC  (SPEC),
        .CNT_W (CNT_W)
    ) u_blk (
        .a    (a_q),
        .nb   (nb_q),
        .k    (cnt_q),
        .sum  (blk_sum),
        .cout (blk_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        nb_d        = nb_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef BCSS_SEQ16_ERR_EN
        err_d       = err_q;
        exact_d     = exact_q;
        ex_sum      = {1'b0, a_q} + {1'b0, nb_q} + (WIDTH+1)'(1);
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    nb_d       = ~b;
                    cnt_d      = '0;
                    diff_d     = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                diff_d[BLK*cnt_q +: BLK] = blk_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NBLK - 1)) begin
                    borrow_d    = ~blk_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef BCSS_SEQ16_ERR_EN
                    exact_d = {~ex_sum[WIDTH], ex_sum[WIDTH-1:0]};
                    err_d   = ({borrow_d, diff_d} != exact_d);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            nb_q        <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BCSS_SEQ16_ERR_EN
            err_q       <= 1'b0;
            exact_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef BCSS_SEQ16_ERR_EN
            err_q       <= err_d;
            exact_q     <= exact_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef BCSS_SEQ16_ERR_EN
    assign err       = err_q;
    assign exact     = exact_q;
`endif

endmodule

// File: tb/tb_bcss_seq16.sv
// Directed bench for bcss_seq16 with hand-computed speculative results.
module tb_bcss_seq16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
`ifdef BCSS_SEQ16_ERR_EN
    logic        err;
    logic [16:0] exact;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat;
    int t0;
    int t1;

    always #5 clk = ~clk;

    bcss_seq16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef BCSS_SEQ16_ERR_EN
        ,
        .err       (err),
        .exact     (exact)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until out_valid is seen; returns cycles taken, or 99 if it never arrives.
    task automatic wait_out(output int n);
        n = 99;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_rdy(output int n);
        n = 99;
        for (int i = 0; i <= 30; i++) begin
            if (in_ready === 1'b1) begin
                n = i;
                break;
            end
            step();
        end
    endtask

    task automatic chk_err(input string tag, input logic e_err, input logic [16:0] e_exact);
`ifdef BCSS_SEQ16_ERR_EN
        chk({tag, "_err"},   32'(err),   32'(e_err));
        chk({tag, "_exact"}, 32'(exact), 32'(e_exact));
`else
        if (e_err === 1'bx) $display("unused %0h", e_exact);
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_borrow",    32'(borrow),    32'd0);
        chk_err("rst", 1'b0, 17'h0);

        // 5 - 3: windows of zero-a / one-nb bits predict carry 0, so upper blocks miss.
        a = 16'h0005; b = 16'h0003; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk("t1_latency", 32'(lat),    32'd8);
        chk("t1_diff",    32'(diff),   32'h0000FFC2);
        chk("t1_borrow",  32'(borrow), 32'd1);
        chk_err("t1", 1'b1, 17'h00002);
        step();
        chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_in_ready_back",  32'(in_ready),  32'd1);

        // 0 - 0: full propagate chain, speculation miss.
        a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk("t2_latency", 32'(lat),    32'd8);
        chk("t2_diff",    32'(diff),   32'h0000FFF0);
        chk("t2_borrow",  32'(borrow), 32'd1);
        chk_err("t2", 1'b1, 17'h00000);
        step();

        // FFFF - 1 with out_ready held low, plus a stray in_valid during RUN.
        a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
        chk("t3_busy_in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
        wait_out(lat);
        chk("t3_latency", 32'(lat),    32'd5);
        chk("t3_diff",    32'(diff),   32'h0000FFFE);
        chk("t3_borrow",  32'(borrow), 32'd0);
        chk_err("t3", 1'b0, 17'h0FFFE);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid",    32'(out_valid), 32'd1);
            chk("t3_hold_in_ready", 32'(in_ready),  32'd0);
            chk("t3_hold_diff",     32'(diff),      32'h0000FFFE);
            chk("t3_hold_borrow",   32'(borrow),    32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("t3_release_valid", 32'(out_valid), 32'd0);
        chk("t3_release_ready", 32'(in_ready),  32'd1);

        // Reset during RUN aborts the operation.
        a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_in_ready",  32'(in_ready),  32'd1);
        chk("t4_diff",      32'(diff),      32'd0);
        chk("t4_borrow",    32'(borrow),    32'd0);
        a = 16'h8000; b = 16'h0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk("t4_latency", 32'(lat),    32'd8);
        chk("t4_diff2",   32'(diff),   32'h00007FF0);
        chk("t4_borrow2", 32'(borrow), 32'd0);
        chk_err("t4", 1'b1, 17'h08000);
        step();

        // Back-to-back with in_valid held high.
        wait_rdy(lat);
        chk("t5_ready_pre", 32'(in_ready), 32'd1);
        a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
        t0 = cyc + 1;
        step();
        a = 16'h8000; b = 16'h0000;
        wait_out(lat);
        chk("t5_diff_a",   32'(diff),   32'h0000FFFE);
        chk("t5_borrow_a", 32'(borrow), 32'd0);
        wait_rdy(lat);
        t1 = cyc + 1;
        chk("t5_accept_gap", 32'(t1 - t0), 32'd10);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        chk("t5_latency_b", 32'(lat),    32'd8);
        chk("t5_diff_b",    32'(diff),   32'h00007FF0);
        chk("t5_borrow_b",  32'(borrow), 32'd0);
        chk_err("t5", 1'b1, 17'h08000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
